// File: rtl/sm_fetch_pkg.sv
// Shared SM fetch definitions: warp/code-memory sizing, PC step and fetch FSM states.
package sm_fetch_pkg;

  localparam int unsigned DEPTH_WARP          = 2;
  localparam int unsigned CODE_MEM_DATA_WIDTH = 64;
  localparam int unsigned PC_INC              = CODE_MEM_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sm_warp_rr_arbiter.sv
// Combinational round-robin pick: first active warp strictly after last_wid, wrapping.
module sm_warp_rr_arbiter #(
  parameter int unsigned NUM_WARP = 4,
  parameter int unsigned WID_W    = 2
) (
  input  logic [NUM_WARP-1:0] active_i,
  input  logic [WID_W-1:0]    last_wid_i,
  output logic [WID_W-1:0]    grant_wid_o,
  output logic                any_o
);

  logic [WID_W-1:0] idx;

  // Scan farthest-to-nearest so the nearest active warp is the last one written.
  always_comb begin
    grant_wid_o = '0;
    idx         = '0;
    any_o       = |active_i;
    for (int i = int'(NUM_WARP); i >= 1; i--) begin
      idx = WID_W'((int'(last_wid_i) + i) % int'(NUM_WARP));
      if (active_i[idx]) grant_wid_o = idx;
    end
  end

endmodule

// File: rtl/sm_fetch.sv
// Per-warp instruction fetch: round-robin warp select, single outstanding code-memory read,
// stale-response discard on branch/exit/relaunch of the in-flight warp.
module sm_fetch #(
  parameter int unsigned NUM_WARP = 1 << sm_fetch_pkg::DEPTH_WARP,
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned PC_INC   = sm_fetch_pkg::PC_INC
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        warp_start_i,
  input  logic [sm_fetch_pkg::DEPTH_WARP-1:0]          warp_start_wid_i,
  input  logic [PC_WIDTH-1:0]                         warp_start_pc_i,
  input  logic                                        warp_done_i,
  input  logic [sm_fetch_pkg::DEPTH_WARP-1:0]          warp_done_wid_i,
  input  logic                                        branch_valid_i,
  input  logic [sm_fetch_pkg::DEPTH_WARP-1:0]          branch_wid_i,
  input  logic [PC_WIDTH-1:0]                         branch_pc_i,
  input  logic                                        stall_i,
  output logic                                        imem_req_valid_o,
  output logic [PC_WIDTH-1:0]                         imem_req_addr_o,
  input  logic                                        imem_req_ready_i,
  input  logic                                        imem_rsp_valid_i,
  input  logic [sm_fetch_pkg::CODE_MEM_DATA_WIDTH-1:0] imem_rsp_data_i,
  output logic                                        valid_o,
  output logic [sm_fetch_pkg::CODE_MEM_DATA_WIDTH-1:0] inst_o,
  output logic [sm_fetch_pkg::DEPTH_WARP-1:0]          wid_o,
  output logic [PC_WIDTH-1:0]                         pc_o,
  output logic [NUM_WARP-1:0]                         active_mask_o
);
  import sm_fetch_pkg::*;

  localparam int unsigned WID_W  = DEPTH_WARP;
  localparam int unsigned DATA_W = CODE_MEM_DATA_WIDTH;

  fetch_state_e         state_q, state_d;
  logic [WID_W-1:0]     sel_wid_q, sel_wid_d;
  logic [WID_W-1:0]     last_wid_q, last_wid_d;
  logic                 discard_q, discard_d;
  logic [NUM_WARP-1:0]  active_q, active_d;
  logic [PC_WIDTH-1:0]  pc_q [NUM_WARP];
  logic [PC_WIDTH-1:0]  pc_d [NUM_WARP];
  logic                 req_valid_q, req_valid_d;
  logic [PC_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    inst_q, inst_d;
  logic [WID_W-1:0]     wid_q, wid_d;
  logic [PC_WIDTH-1:0]  pc_out_q, pc_out_d;

  logic [WID_W-1:0]     grant_wid;
  logic                 grant_any;

  sm_warp_rr_arbiter #(
    .NUM_WARP (NUM_WARP),
    .WID_W    (WID_W)
  ) u_arb (
    .active_i    (active_q),
    .last_wid_i  (last_wid_q),
    .grant_wid_o (grant_wid),
    .any_o       (grant_any)
  );

  // True when a control event this cycle invalidates the PC fetched for warp w.
  function automatic logic touches(input logic [WID_W-1:0] w,
                                   input logic b_v, input logic [WID_W-1:0] b_w,
                                   input logic d_v, input logic [WID_W-1:0] d_w,
                                   input logic s_v, input logic [WID_W-1:0] s_w);
    return (b_v && b_w == w) || (d_v && d_w == w) || (s_v && s_w == w);
  endfunction

  always_comb begin
    state_d    = state_q;
    sel_wid_d  = sel_wid_q;
    last_wid_d = last_wid_q;
    discard_d  = discard_q;
    active_d   = active_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    valid_d    = 1'b0;
    inst_d     = inst_q;
    wid_d      = wid_q;
    pc_out_d   = pc_out_q;

    unique case (state_q)
      FETCH_IDLE: begin
        if (!stall_i && grant_any) begin
          sel_wid_d  = grant_wid;
          req_addr_d = pc_q[grant_wid];
          // discard tracks the newly selected fetch from here until its response returns
          discard_d  = touches(grant_wid, branch_valid_i, branch_wid_i,
                               warp_done_i, warp_done_wid_i, warp_start_i, warp_start_wid_i);
          state_d    = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (imem_req_ready_i) begin
          last_wid_d = sel_wid_q;
          state_d    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid_i) begin
          state_d = FETCH_IDLE;
          if (!discard_q) begin
            valid_d          = 1'b1;
            inst_d           = imem_rsp_data_i;
            wid_d            = sel_wid_q;
            pc_out_d         = pc_q[sel_wid_q];
            pc_d[sel_wid_q]  = pc_q[sel_wid_q] + PC_WIDTH'(PC_INC);
          end
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    if (state_q != FETCH_IDLE &&
        touches(sel_wid_q, branch_valid_i, branch_wid_i,
                warp_done_i, warp_done_wid_i, warp_start_i, warp_start_wid_i)) begin
      discard_d = 1'b1;
    end

    // Branch overrides the increment; launch overrides both and beats exit.
    for (int w = 0; w < int'(NUM_WARP); w++) begin
      if (branch_valid_i && branch_wid_i == WID_W'(w)) pc_d[w] = branch_pc_i;
      if (warp_done_i && warp_done_wid_i == WID_W'(w)) active_d[w] = 1'b0;
      if (warp_start_i && warp_start_wid_i == WID_W'(w)) begin
        active_d[w] = 1'b1;
        pc_d[w]     = warp_start_pc_i;
      end
    end

    req_valid_d = (state_d == FETCH_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH_IDLE;
      sel_wid_q   <= '0;
      last_wid_q  <= '0;
      discard_q   <= 1'b0;
      active_q    <= '0;
      for (int w = 0; w < int'(NUM_WARP); w++) pc_q[w] <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      wid_q       <= '0;
      pc_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_wid_q   <= sel_wid_d;
      last_wid_q  <= last_wid_d;
      discard_q   <= discard_d;
      active_q    <= active_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      wid_q       <= wid_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = req_addr_q;
  assign valid_o          = valid_q;
  assign inst_o           = inst_q;
  assign wid_o            = wid_q;
  assign pc_o             = pc_out_q;
  assign active_mask_o    = active_q;

endmodule

// File: tb/tb_sm_fetch.sv
// Directed bench for sm_fetch: code memory returns {~addr, addr} after a programmable delay.
module tb_sm_fetch;
  import sm_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        warp_start_i;
  logic [1:0]  warp_start_wid_i;
  logic [31:0] warp_start_pc_i;
  logic        warp_done_i;
  logic [1:0]  warp_done_wid_i;
  logic        branch_valid_i;
  logic [1:0]  branch_wid_i;
  logic [31:0] branch_pc_i;
  logic        stall_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [63:0] imem_rsp_data_i;
  logic        valid_o;
  logic [63:0] inst_o;
  logic [1:0]  wid_o;
  logic [31:0] pc_o;
  logic [3:0]  active_mask_o;

  int total = 0;
  int bad   = 0;

  logic [1:0]  mq_wid[$];
  logic [31:0] mq_pc[$];
  logic [63:0] mq_inst[$];

  bit          rsp_en = 1'b0;
  int          rsp_lat = 0;
  bit          armed = 1'b0;
  int          cnt = 0;
  logic [31:0] rsp_addr = '0;
  logic        man_rsp_valid = 1'b0;
  logic [63:0] man_rsp_data = '0;

  always #5 clk = ~clk;

  sm_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .warp_start_i     (warp_start_i),
    .warp_start_wid_i (warp_start_wid_i),
    .warp_start_pc_i  (warp_start_pc_i),
    .warp_done_i      (warp_done_i),
    .warp_done_wid_i  (warp_done_wid_i),
    .branch_valid_i   (branch_valid_i),
    .branch_wid_i     (branch_wid_i),
    .branch_pc_i      (branch_pc_i),
    .stall_i          (stall_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .valid_o          (valid_o),
    .inst_o           (inst_o),
    .wid_o            (wid_o),
    .pc_o             (pc_o),
    .active_mask_o    (active_mask_o)
  );

  // Delivery monitor
  always @(negedge clk) begin
    if (valid_o) begin
      mq_wid.push_back(wid_o);
      mq_pc.push_back(pc_o);
      mq_inst.push_back(inst_o);
    end
  end

  // Code memory: response rsp_lat cycles after the minimum one-cycle latency
  always @(negedge clk) begin
    if (rsp_en) begin
      imem_rsp_valid_i = 1'b0;
      if (armed) begin
        if (cnt == 0) begin
          imem_rsp_valid_i = 1'b1;
          imem_rsp_data_i  = {~rsp_addr, rsp_addr};
          armed = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        armed    = 1'b1;
        cnt      = rsp_lat;
        rsp_addr = imem_req_addr_o;
      end
    end else begin
      armed = 1'b0;
      imem_rsp_valid_i = man_rsp_valid;
      imem_rsp_data_i  = man_rsp_data;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    mq_wid.delete();
    mq_pc.delete();
    mq_inst.delete();
  endtask

  task automatic wait_q(input int n, input string tag);
    for (int i = 0; i < 300 && mq_wid.size() < n; i++) step();
    chk(tag, 64'(mq_wid.size() >= n), 64'd1);
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] ewid, input logic [31:0] epc);
    logic [1:0]  w;
    logic [31:0] p;
    logic [63:0] d;
    if (mq_wid.size() == 0) begin
      chk({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      w = mq_wid.pop_front();
      p = mq_pc.pop_front();
      d = mq_inst.pop_front();
      chk({tag, "_wid"}, 64'(w), 64'(ewid));
      chk({tag, "_pc"}, 64'(p), 64'(epc));
      chk({tag, "_inst"}, d, {~epc, epc});
    end
  endtask

  // Wait for a presented request; nib selects the warp's code region, 16 means any
  task automatic wait_req(input int nib, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (imem_req_valid_o && (nib == 16 || int'(imem_req_addr_o[15:12]) == nib)) hit = 1'b1;
      else step();
    end
    chk(tag, 64'(hit), 64'd1);
  endtask

  task automatic start_warp(input logic [1:0] w, input logic [31:0] pc);
    warp_start_i     = 1'b1;
    warp_start_wid_i = w;
    warp_start_pc_i  = pc;
    step();
    warp_start_i     = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_inst"}, inst_o, 64'd0);
    chk({tag, "_wid"}, 64'(wid_o), 64'd0);
    chk({tag, "_pc"}, 64'(pc_o), 64'd0);
    chk({tag, "_reqv"}, 64'(imem_req_valid_o), 64'd0);
    chk({tag, "_reqa"}, 64'(imem_req_addr_o), 64'd0);
    chk({tag, "_mask"}, 64'(active_mask_o), 64'd0);
  endtask

  initial begin
    int reqs;
    rst_n = 1'b0;
    warp_start_i = 1'b0; warp_start_wid_i = '0; warp_start_pc_i = '0;
    warp_done_i = 1'b0; warp_done_wid_i = '0;
    branch_valid_i = 1'b0; branch_wid_i = '0; branch_pc_i = '0;
    stall_i = 1'b0; imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    rsp_en = 1'b1;
    repeat (3) step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) step();
    chk_idle_outputs("post_reset");

    // Basic fetch on warp 0
    start_warp(2'd0, 32'h100);
    wait_q(3, "basic_cnt");
    pop_chk("basic0", 2'd0, 32'h100);
    pop_chk("basic1", 2'd0, 32'h108);
    pop_chk("basic2", 2'd0, 32'h110);
    warp_done_i = 1'b1; warp_done_wid_i = 2'd0;
    step();
    warp_done_i = 1'b0;
    repeat (10) step();
    chk("basic_mask", 64'(active_mask_o), 64'd0);
    clear_q();

    // Round-robin over warps 0,1,3
    start_warp(2'd0, 32'h1000);
    start_warp(2'd1, 32'h2000);
    start_warp(2'd3, 32'h3000);
    chk("rr_mask", 64'(active_mask_o), 64'hB);
    wait_q(6, "rr_cnt");
    pop_chk("rr0", 2'd0, 32'h1000);
    pop_chk("rr1", 2'd1, 32'h2000);
    pop_chk("rr2", 2'd3, 32'h3000);
    pop_chk("rr3", 2'd0, 32'h1008);
    pop_chk("rr4", 2'd1, 32'h2008);
    pop_chk("rr5", 2'd3, 32'h3008);

    // Branch warp 1 while its fetch of 0x2010 is in WAIT
    rsp_lat = 2;
    wait_req(2, "br_req_seen");
    chk("br_req_addr", 64'(imem_req_addr_o), 64'h2010);
    step();
    branch_valid_i = 1'b1; branch_wid_i = 2'd1; branch_pc_i = 32'h400;
    clear_q();
    step();
    branch_valid_i = 1'b0;
    wait_q(3, "br_cnt");
    pop_chk("br0", 2'd3, 32'h3010);
    pop_chk("br1", 2'd0, 32'h1018);
    pop_chk("br2", 2'd1, 32'h400);

    // Exit warp 3 while its fetch of 0x3018 is in WAIT
    wait_req(3, "done_req_seen");
    chk("done_req_addr", 64'(imem_req_addr_o), 64'h3018);
    step();
    warp_done_i = 1'b1; warp_done_wid_i = 2'd3;
    clear_q();
    step();
    warp_done_i = 1'b0;
    chk("done_mask", 64'(active_mask_o), 64'h3);
    wait_q(3, "done_cnt");
    pop_chk("done0", 2'd0, 32'h1020);
    pop_chk("done1", 2'd1, 32'h408);
    pop_chk("done2", 2'd0, 32'h1028);

    // Stall asserted with a request outstanding: that one still delivers, nothing new issues
    rsp_lat = 0;
    wait_req(16, "stall_req_seen");
    stall_i = 1'b1;
    clear_q();
    reqs = 0;
    step();
    repeat (20) begin
      step();
      if (imem_req_valid_o) reqs++;
    end
    chk("stall_reqs", 64'(reqs), 64'd0);
    chk("stall_deliv", 64'(mq_wid.size()), 64'd1);
    stall_i = 1'b0;

    // Reset while in WAIT, then a late response
    rsp_lat = 3;
    wait_req(16, "rst_req_seen");
    step();
    rst_n  = 1'b0;
    rsp_en = 1'b0;
    clear_q();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    man_rsp_valid = 1'b1;
    man_rsp_data  = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    man_rsp_valid = 1'b0;
    repeat (3) step();
    chk_idle_outputs("rst_wait");
    chk("rst_wait_deliv", 64'(mq_wid.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
